// File: rtl/pll_sync_tx.sv
// Fast-to-slow transmitter for a PLL-synchronous clock pair: buffers fast-domain words
// and launches at most one per slow period at a fixed phase, gated by a phase-lock check.
module pll_sync_tx #(
    parameter int RATIO        = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LAUNCH_PHASE = RATIO / 2
) (
    input  logic                          fst_clk,
    input  logic                          rst_n,
    input  logic [$clog2(RATIO)-1:0]      ctr,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    output logic                          dout_stb,
    output logic                          locked,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW  = $clog2(RATIO);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int LCW = $clog2(2 * RATIO);

    localparam logic [CW-1:0]  LAUNCH_CTR = CW'(LAUNCH_PHASE);
    localparam logic [LCW-1:0] LOCK_LAST  = LCW'(2 * RATIO - 1);
    localparam logic [LW-1:0]  FULL_LVL   = LW'(FIFO_DEPTH);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [LCW-1:0]          lock_cnt;
    logic [LCW-1:0]          lock_cnt_nxt;
    logic [CW-1:0]           ctr_q;
    logic                    seq_ok;
    logic                    launch;
    logic                    desync;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;

    // A clean step means the phase count advanced by exactly one, wrapping RATIO-1 -> 0.
    assign seq_ok    = (ctr == CW'(ctr_q + 1'b1));
    assign din_ready = rst_n && (fifo_level != FULL_LVL);
    assign push      = din_valid && din_ready;
    assign pop       = launch && (fifo_level != '0);

    always_ff @(posedge fst_clk) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            ctr_q    <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            ctr_q    <= ctr;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            UNLOCKED: begin
                if (!seq_ok) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (!seq_ok) begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
        launch = 1'b0;
        desync = 1'b0;
        if (state == LOCKED) begin
            launch = seq_ok && (ctr == LAUNCH_CTR);
            desync = !seq_ok;
        end
    end

    always_ff @(posedge fst_clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge fst_clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge fst_clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_stb   <= 1'b0;
        end else begin
            dout_stb <= pop;
            if (pop) begin
                dout       <= mem[rd_ptr];
                dout_valid <= 1'b1;
            end else if (launch || desync) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_sync_tx.sv
// Directed bench for pll_sync_tx: table-driven reset/lock vectors plus hand-written
// sequences for launch, backpressure, glitch, simultaneous push/pop and mid-run reset.
module tb_pll_sync_tx;

    localparam int RATIO = 8;

    logic        fst_clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ctr;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_stb;
    logic        locked;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    pll_sync_tx #(
        .RATIO(8), .DATA_WIDTH(16), .FIFO_DEPTH(4), .LAUNCH_PHASE(4)
    ) dut (
        .fst_clk(fst_clk), .rst_n(rst_n), .ctr(ctr), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_stb(dout_stb),
        .locked(locked), .fifo_level(fifo_level)
    );

    always #5 fst_clk = ~fst_clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] ctr;
        logic       exp_locked;
        logic [2:0] exp_level;
        logic       exp_ready;
        logic       exp_dv;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One fast edge, sample just after it, then step the phase count for the next edge.
    task automatic adv();
        @(posedge fst_clk);
        #1;
        ctr = ctr + 3'd1;
    endtask

    task automatic run_to(input logic [2:0] target);
        for (int k = 0; k < RATIO && ctr != target; k++) adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nv, ns, nxt, nl, last_t;
        logic acc;
        logic [15:0] q[$];

        rst_n = 1'b0; ctr = 3'd0; din = '0; din_valid = 1'b0;

        tbl[0] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0};
        for (int i = 2; i < 18; i++)
            tbl[i] = '{1'b1, 3'(i - 1), (i == 17), 3'd0, 1'b1, 1'b0};

        // Reset, then a clean sweep from 0: lock after exactly 16 good steps.
        for (int i = 0; i < 18; i++) begin
            rst_n = tbl[i].rst_n;
            ctr   = tbl[i].ctr;
            @(posedge fst_clk);
            #1;
            chk($sformatf("lock[%0d].locked", i), locked, tbl[i].exp_locked);
            chk($sformatf("lock[%0d].level", i), fifo_level, tbl[i].exp_level);
            chk($sformatf("lock[%0d].ready", i), din_ready, tbl[i].exp_ready);
            chk($sformatf("lock[%0d].dout_valid", i), dout_valid, tbl[i].exp_dv);
            chk($sformatf("lock[%0d].dout_stb", i), dout_stb, 1'b0);
            chk($sformatf("lock[%0d].dout", i), dout, 16'h0);
        end
        ctr = 3'd1;

        // Single word pushed at phase 6, launched at the next phase 4.
        run_to(3'd6);
        din = 16'hBEEF; din_valid = 1'b1;
        chk("sw_ready", din_ready, 1'b1);
        adv();
        din_valid = 1'b0;
        chk("sw_level_push", fifo_level, 3'd1);
        run_to(3'd4);
        adv();
        chk("sw_dout", dout, 16'hBEEF);
        chk("sw_stb", dout_stb, 1'b1);
        chk("sw_valid", dout_valid, 1'b1);
        chk("sw_level_pop", fifo_level, 3'd0);
        nv = 0; ns = 0;
        for (int k = 0; k < 7; k++) begin
            adv();
            if (dout_valid) nv++;
            if (dout_stb) ns++;
        end
        chk("sw_valid_hold", nv, 7);
        chk("sw_stb_single", ns, 0);
        adv();
        chk("sw_valid_drop", dout_valid, 1'b0);
        chk("sw_dout_held", dout, 16'hBEEF);
        chk("sw_no_stb", dout_stb, 1'b0);

        // Backpressure: six words back-to-back into a four-deep buffer.
        nxt = 1; nl = 0; last_t = -1;
        din = 16'd1; din_valid = 1'b1;
        for (int c = 0; c < 80 && nl < 6; c++) begin
            acc = din_valid && din_ready;
            adv();
            if (acc) begin
                q.push_back(din);
                if (nxt == 4) begin
                    chk("bp_level_full", fifo_level, 3'd4);
                    chk("bp_ready_full", din_ready, 1'b0);
                end
                nxt++;
                if (nxt <= 6) din = 16'(nxt);
                else din_valid = 1'b0;
            end
            if (dout_stb) begin
                if (q.size() == 0) begin
                    chk("bp_unexpected_stb", dout_stb, 1'b0);
                end else begin
                    chk("bp_order", dout, q.pop_front());
                    chk("bp_ready_reopen", din_ready, 1'b1);
                    if (last_t >= 0) chk("bp_spacing", c - last_t, RATIO);
                    last_t = c;
                    nl++;
                end
            end
        end
        chk("bp_launches", nl, 6);

        // Glitch while locked with two words buffered.
        din = 16'h00A1; din_valid = 1'b1;
        adv();
        din = 16'h00A2;
        adv();
        din_valid = 1'b0;
        chk("gl_level_pre", fifo_level, 3'd2);
        run_to(3'd3);
        adv();
        chk("gl_valid_pre", dout_valid, 1'b1);
        ctr = 3'd1;
        adv();
        chk("gl_locked", locked, 1'b0);
        chk("gl_valid", dout_valid, 1'b0);
        chk("gl_stb", dout_stb, 1'b0);
        chk("gl_level", fifo_level, 3'd2);
        chk("gl_dout_held", dout, 16'd6);
        ns = 0;
        for (int k = 1; k <= 16; k++) begin
            adv();
            if (dout_stb) ns++;
            if (k == 15) chk("gl_locked_15", locked, 1'b0);
            if (k == 16) chk("gl_locked_16", locked, 1'b1);
        end
        chk("gl_no_launch", ns, 0);
        chk("gl_level_relock", fifo_level, 3'd2);
        run_to(3'd4);
        adv();
        chk("gl_first_word", dout, 16'h00A1);
        chk("gl_first_stb", dout_stb, 1'b1);
        chk("gl_level_1", fifo_level, 3'd1);
        run_to(3'd4);
        adv();
        chk("gl_second_word", dout, 16'h00A2);
        chk("gl_level_0", fifo_level, 3'd0);

        // Full buffer, push attempt on a launch cycle.
        for (int w = 0; w < 4; w++) begin
            din = 16'hB000 + 16'(w); din_valid = 1'b1;
            adv();
        end
        din_valid = 1'b0;
        chk("sim_level_full", fifo_level, 3'd4);
        run_to(3'd4);
        din = 16'hDEAD; din_valid = 1'b1;
        chk("sim_ready_pre", din_ready, 1'b0);
        adv();
        din_valid = 1'b0;
        chk("sim_level", fifo_level, 3'd3);
        chk("sim_ready_post", din_ready, 1'b1);
        chk("sim_stb", dout_stb, 1'b1);
        chk("sim_dout", dout, 16'hB000);
        chk("sim_valid", dout_valid, 1'b1);

        // One-cycle reset with three words buffered and dout valid.
        rst_n = 1'b0;
        adv();
        chk("rst_dout", dout, 16'h0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_stb", dout_stb, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ready_low", din_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_high", din_ready, 1'b1);

        // Relock from start value 5; a word pushed while unlocked is the only one emitted.
        ctr = 3'd5; din = 16'h0077; din_valid = 1'b1;
        adv();
        din_valid = 1'b0;
        chk("rl_unlocked_push", fifo_level, 3'd1);
        ns = 0;
        for (int k = 1; k <= 16; k++) begin
            adv();
            if (dout_stb) ns++;
            if (k == 15) chk("rl_locked_15", locked, 1'b0);
            if (k == 16) chk("rl_locked_16", locked, 1'b1);
        end
        chk("rl_no_launch", ns, 0);
        for (int k = 0; k < 20 && !dout_stb; k++) adv();
        chk("rl_stb", dout_stb, 1'b1);
        chk("rl_word", dout, 16'h0077);
        ns = 0;
        for (int k = 0; k < 16; k++) begin
            adv();
            if (dout_stb) ns++;
        end
        chk("rl_no_stale", ns, 0);
        chk("rl_level", fifo_level, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_sync_tx.md
Name: pll_sync_tx

Overview:
Fast-to-slow transmitter for the PLL-synchronous clock pair. Runs entirely on the fast clock and consumes the phase count produced by the fast-domain phase counter (0..RATIO-1, one full sweep per slow-clock period). Buffers fast-domain words in a small FIFO and launches at most one word per slow period, always at a fixed phase, so the slow domain samples a value that is stable for a whole slow period. Launching is gated by a lock detector that checks the phase count is sequencing cleanly.

Parameters:
RATIO, 8, slow-clock period / fast-clock period; power of two, ≥4
DATA_WIDTH, 16, payload width
FIFO_DEPTH, 4, buffer depth in words; power of two, ≥2
LAUNCH_PHASE, 4, phase count value on which dout updates; < RATIO; default RATIO/2 keeps updates mid-period, away from the slow edge

Ports:
fst_clk  in  1  fast clock; the only clock in the block
rst_n  in  1  synchronous reset, active low
ctr  in  $clog2(RATIO)  phase count from the fast-domain phase counter
din  in  DATA_WIDTH  payload word
din_valid  in  1  din presented
din_ready  out  1  FIFO can accept; transfer when din_valid && din_ready
dout  out  DATA_WIDTH  word to slow domain; changes only on launch cycles
dout_valid  out  1  dout holds a fresh word for the current slow period
dout_stb  out  1  one-cycle pulse when dout is loaded with a new word
locked  out  1  phase count is sequencing correctly
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (rst_n low at a fst_clk edge):
  - FIFO emptied; fifo_level=0.
  - dout=0, dout_valid=0, dout_stb=0, locked=0.
  - State UNLOCKED; lock_cnt=0; ctr_q=0.
  - din_ready=0 while rst_n is low. Reset mid-burst discards buffered words.
- din_ready = rst_n && (fifo_level != FIFO_DEPTH). This is combinational from registered state, so there is no input latency.
- Sequence check:
  - ctr_q is registered ctr.
  - seq_ok = (ctr == ctr_q+1 mod RATIO), i.e. RATIO-1 is followed by 0.
- State machine:
  - UNLOCKED:
    - seq_ok: lock_cnt++.
    - !seq_ok: lock_cnt=0.
    - When seq_ok with lock_cnt==2*RATIO-1 (2*RATIO consecutive good steps): go to LOCKED, locked=1 next cycle.
  - LOCKED, !seq_ok (e.g. a slow-edge resync of the counter):
    - go to UNLOCKED, lock_cnt=0, locked=0.
    - dout_valid=0 next cycle; dout holds its value.
    - FIFO contents kept; no launch in this cycle.
- Launch, in LOCKED with seq_ok and ctr==LAUNCH_PHASE:
  - FIFO non-empty: dout<=head, pop, dout_valid<=1, dout_stb<=1 for one cycle.
  - FIFO empty: dout_valid<=0, dout held, no strobe.
  - Outside launch cycles, dout and dout_valid are held. dout_stb is 0 in all other cycles.
- Latency:
  - A word pushed at cycle t is not bypassed. It is launched at the first launch cycle ≥ t+1 for which it is at the head.
  - Maximum rate is one word per RATIO cycles.
- FIFO ordering and counts:
  - Ordering is strict FIFO; the read and write pointers wrap mod FIFO_DEPTH.
  - Push and pop in the same cycle: fifo_level unchanged.
  - Push while full is impossible (din_ready=0); din is ignored.
  - Pop while empty never occurs.
  - A pop at full raises din_ready the following cycle.
- While UNLOCKED, pushes are still accepted until full, and nothing is launched.

Test Plan:
- Lock: RATIO=8, ctr sweeps 0..7 cleanly from reset. locked rises exactly after 16 good steps. Start ctr at 5 and verify the lock count is unaffected by the start value.
- Single word: locked; push 0xBEEF when ctr=6. On the next ctr==4 cycle, dout=0xBEEF next edge, dout_stb pulses 1 cycle, dout_valid=1 for 8 cycles. With no further data, dout_valid drops at the following launch and dout stays 0xBEEF.
- Backpressure: locked; push 6 words 1..6 back-to-back. din_ready deasserts after 4 and fifo_level=4. Words 1..6 appear on dout in order, one per 8 cycles, with din_ready re-opening after each pop.
- Glitch: locked with 2 words buffered; force ctr 3→1. Required: locked=0 and dout_valid=0 next cycle, no launch, fifo_level stays 2. After 16 clean steps, relock and resume launching word order unchanged.
- Simultaneous: at full, push attempt during a launch cycle. Push refused, pop occurs, fifo_level=3, din_ready=1 the next cycle.
- Reset mid-operation: assert rst_n low for 1 cycle with 3 words buffered and dout_valid=1. Next cycle all outputs are at reset values. No buffered word is ever emitted after reset.
